manchester_framer: RTL and testbench
====================================

MANCHESTER_FRAMER -- requirements
Module: manchester_framer

Interface
REQ-001 Parameter DATA_WIDTH, default 8: byte/symbol width of both AXI-Stream ports.
REQ-002 Parameter SOF_SYMBOL, default 8'hD5: start-of-frame delimiter, reserved in payload.
REQ-003 Parameter ESC_SYMBOL, default 8'hE5: escape prefix, reserved in payload.
REQ-004 Parameter ESC_XOR, default 8'h20: mask XORed onto an escaped payload byte.
REQ-005 Parameter INSERT_SOF, default 1: 1 = prepend SOF_SYMBOL to every frame; 0 = escaping only.
REQ-006 Parameter CNT_WIDTH, default 16: width of statistics counters.
REQ-007 aclk  in  1  single clock, all logic on rising edge.
REQ-008 aresetn  in  1  reset, synchronous and active-low.
REQ-009 s_axis_tdata  in  DATA_WIDTH  payload byte.
REQ-010 s_axis_tvalid  in  1 / s_axis_tready  out  1 / s_axis_tlast  in  1  input handshake and end-of-frame.
REQ-011 m_axis_tdata  out  DATA_WIDTH / m_axis_tvalid  out  1 / m_axis_tready  in  1 / m_axis_tlast  out  1  framed output stream.
REQ-012 stat_frames  out  CNT_WIDTH  count of output beats with tlast accepted; wraps modulo 2^CNT_WIDTH.
REQ-013 stat_escapes  out  CNT_WIDTH  count of ESC_SYMBOL prefixes accepted downstream; wraps.

Function
REQ-014 Output is a single register stage (out_valid/out_data/out_last); load_ok = !out_valid || m_axis_tready; m_axis_tvalid/tdata/tlast driven only from it.
REQ-015 Once m_axis_tvalid is high, tdata/tlast SHALL hold until m_axis_tready is sampled high.
REQ-016 FSM states: S_SOF (frame boundary), S_DATA (in frame), S_ESC (second beat of escape pending).
REQ-017 S_SOF, INSERT_SOF=1: s_axis_tready=0; when s_axis_tvalid && load_ok load SOF_SYMBOL, tlast=0, go S_DATA; no SOF emitted without pending input.
REQ-018 S_SOF, INSERT_SOF=0: behaves identically to S_DATA.
REQ-019 S_DATA: s_axis_tready = load_ok; on accept of byte b equal to SOF_SYMBOL or ESC_SYMBOL load ESC_SYMBOL with tlast=0, capture b^ESC_XOR and s_axis_tlast into hold register, go S_ESC.
REQ-020 S_DATA, any other b: load b with tlast=s_axis_tlast; next state S_SOF if tlast else S_DATA.
REQ-021 S_ESC: s_axis_tready=0; when load_ok load hold byte with hold tlast; next state S_SOF if hold tlast else S_DATA.
REQ-022 tlast of an escaped final byte SHALL appear only on the second (XORed) beat, never on ESC_SYMBOL.
REQ-023 Latency: accepted input to m_axis_tvalid is 1 cycle; S_DATA with m_axis_tready=1 sustains one beat per cycle.
REQ-024 Statistics increment on output handshake (m_axis_tvalid && m_axis_tready) only; simultaneous increments of both counters allowed.

Reset
REQ-025 aresetn low at a rising edge: state=S_SOF, out_valid=0, out_data=0, out_last=0, hold cleared, both counters=0, s_axis_tready=0 that cycle.
REQ-026 Reset mid-frame or in S_ESC discards the partial frame and pending hold byte; next accepted byte starts a new frame.

Structure
REQ-027 Default symbol constants (SOF, ESC, XOR mask) and FSM state encoding SHALL live in shared package manchester_pkg.
REQ-028 Output register SHALL be a sub-module axis_out_reg (valid/data/last, load_ok); FSM and counters stay in manchester_framer.

Verification
REQ-029 Frame 11,22,33(last), m_axis_tready=1 -> D5,11,22,33[TLAST]; stat_frames=1, stat_escapes=0.
REQ-030 Frame D5,11,E5(last) -> D5,E5,F5,11,E5,C5[TLAST]; stat_escapes=2.
REQ-031 Two back-to-back frames 44(last),55(last) -> D5,44[TLAST],D5,55[TLAST]; stat_frames=2.
REQ-032 m_axis_tready toggled 1/0 every cycle during REQ-030 frame -> identical byte sequence, no beat dropped/duplicated, tdata stable while stalled.
REQ-033 INSERT_SOF=0, frame 10,D5(last) -> 10,E5,F5[TLAST], no leading D5.
REQ-034 aresetn low for 1 cycle while in S_ESC after input E5 -> no F5 emitted; following frame 66(last) -> D5,66[TLAST]; counters read 0 before it.

Source files
------------

// File: rtl/manchester_pkg.sv
// Shared symbol defaults and FSM state encoding for the Manchester framer.
package manchester_pkg;

  localparam logic [7:0] SOF_DEFAULT = 8'hD5;
  localparam logic [7:0] ESC_DEFAULT = 8'hE5;
  localparam logic [7:0] XOR_DEFAULT = 8'h20;

  typedef enum logic [1:0] {
    S_SOF  = 2'd0,
    S_DATA = 2'd1,
    S_ESC  = 2'd2
  } state_t;

endpackage

// File: rtl/manchester_framer_if.sv
// AXI-Stream style handshake bundle used for both framer ports.
interface manchester_framer_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_out_reg.sv
// Single output register stage; contents hold until the downstream takes them.
module axis_out_reg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  input  logic                  ready,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  last,
  output logic                  load_ok
);

  assign load_ok = !valid || ready;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      valid <= 1'b0;
      data  <= '0;
      last  <= 1'b0;
    end else if (load_ok) begin
      valid <= load;
      if (load) begin
        data <= load_data;
        last <= load_last;
      end
    end
  end

endmodule

// File: rtl/manchester_framer.sv
// Byte-stream framer: optional SOF delimiter, escaping of reserved symbols,
// and wrapping frame/escape statistics counted on the output handshake.
//
// state  | meaning
// S_SOF  | frame boundary; emits SOF once input is pending (or acts as S_DATA)
// S_DATA | inside a frame; payload bytes pass or start an escape
// S_ESC  | escape prefix sent; XORed byte waiting in the hold register
module manchester_framer
  import manchester_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] SOF_SYMBOL = DATA_WIDTH'(SOF_DEFAULT),
  parameter logic [DATA_WIDTH-1:0] ESC_SYMBOL = DATA_WIDTH'(ESC_DEFAULT),
  parameter logic [DATA_WIDTH-1:0] ESC_XOR    = DATA_WIDTH'(XOR_DEFAULT),
  parameter bit                    INSERT_SOF = 1'b1,
  parameter int                    CNT_WIDTH  = 16
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  manchester_framer_if.slave   s_axis,
  manchester_framer_if.master  m_axis,
  output logic [CNT_WIDTH-1:0] stat_frames,
  output logic [CNT_WIDTH-1:0] stat_escapes
);

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] hold_data;
  logic                  hold_last;
  logic                  capture;
  logic                  load, load_last, load_ok;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  in_ready;
  logic                  out_valid, out_last;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  reserved, data_phase, accept;

  assign reserved   = (s_axis.tdata == SOF_SYMBOL) || (s_axis.tdata == ESC_SYMBOL);
  assign data_phase = (state == S_DATA) || ((state == S_SOF) && !INSERT_SOF);
  assign accept     = s_axis.tvalid && load_ok;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state     <= S_SOF;
      hold_data <= '0;
      hold_last <= 1'b0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        hold_data <= s_axis.tdata ^ ESC_XOR;
        hold_last <= s_axis.tlast;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    load_data = '0;
    load_last = 1'b0;
    in_ready  = 1'b0;
    capture   = 1'b0;
    // Nothing is accepted while reset is asserted so no byte is silently lost.
    if (aresetn) begin
      case (state)
        S_ESC: begin
          if (load_ok) begin
            load      = 1'b1;
            load_data = hold_data;
            load_last = hold_last;
            state_nxt = hold_last ? S_SOF : S_DATA;
          end
        end
        default: begin
          if (!data_phase) begin
            if (accept) begin
              load      = 1'b1;
              load_data = SOF_SYMBOL;
              state_nxt = S_DATA;
            end
          end else begin
            in_ready = load_ok;
            if (accept && reserved) begin
              // tlast rides on the XORed beat, never on the prefix.
              load      = 1'b1;
              load_data = ESC_SYMBOL;
              capture   = 1'b1;
              state_nxt = S_ESC;
            end else if (accept) begin
              load      = 1'b1;
              load_data = s_axis.tdata;
              load_last = s_axis.tlast;
              state_nxt = s_axis.tlast ? S_SOF : S_DATA;
            end
          end
        end
      endcase
    end
  end

  assign s_axis.tready = in_ready;

  axis_out_reg #(.DATA_WIDTH(DATA_WIDTH)) u_out (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .load      (load),
    .load_data (load_data),
    .load_last (load_last),
    .ready     (m_axis.tready),
    .valid     (out_valid),
    .data      (out_data),
    .last      (out_last),
    .load_ok   (load_ok)
  );

  assign m_axis.tvalid = out_valid;
  assign m_axis.tdata  = out_data;
  assign m_axis.tlast  = out_last;

  // Payload never carries ESC_SYMBOL unescaped, so an ESC beat is always a prefix.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      stat_frames  <= '0;
      stat_escapes <= '0;
    end else if (out_valid && m_axis.tready) begin
      if (out_last) stat_frames <= stat_frames + CNT_WIDTH'(1);
      if (out_data == ESC_SYMBOL && !out_last) stat_escapes <= stat_escapes + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_manchester_framer.sv
// Self-checking bench: directed frames plus random traffic against a list-based framing model.
module tb_manchester_framer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;
  manchester_framer_if #(.DATA_WIDTH(8)) s1 (), m1 (), s0 (), m0 ();
  logic [15:0] fr1, es1, fr0, es0;

  manchester_framer #(.INSERT_SOF(1'b1)) dut1 (
    .aclk(clk), .aresetn(rstn), .s_axis(s1.slave), .m_axis(m1.master),
    .stat_frames(fr1), .stat_escapes(es1));

  manchester_framer #(.INSERT_SOF(1'b0)) dut0 (
    .aclk(clk), .aresetn(rstn), .s_axis(s0.slave), .m_axis(m0.master),
    .stat_frames(fr0), .stat_escapes(es0));

  int total = 0;
  int bad   = 0;
  int rdy_mode = 0;
  logic [8:0] exp1[$], got1[$], exp0[$], got0[$];
  logic [7:0] frm[$];
  int exp_fr1 = 0, exp_es1 = 0, exp_fr0 = 0, exp_es0 = 0;
  logic hs1, hs0, stall1 = 1'b0, stall0 = 1'b0;
  logic [8:0] prev1, prev0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: sample everything at the falling edge, then update sink ready after the rising edge.
  task automatic step();
    logic r;
    @(negedge clk);
    hs1 = rstn && s1.tvalid && s1.tready;
    hs0 = rstn && s0.tvalid && s0.tready;
    if (rstn) begin
      if (stall1) chk("hold1", 32'({m1.tvalid, m1.tlast, m1.tdata}), 32'({1'b1, prev1}));
      if (stall0) chk("hold0", 32'({m0.tvalid, m0.tlast, m0.tdata}), 32'({1'b1, prev0}));
      if (m1.tvalid && m1.tready) got1.push_back({m1.tlast, m1.tdata});
      if (m0.tvalid && m0.tready) got0.push_back({m0.tlast, m0.tdata});
      stall1 = m1.tvalid && !m1.tready;
      stall0 = m0.tvalid && !m0.tready;
      prev1  = {m1.tlast, m1.tdata};
      prev0  = {m0.tlast, m0.tdata};
    end else begin
      stall1 = 1'b0;
      stall0 = 1'b0;
    end
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       r = 1'b1;
      1:       r = !m1.tready;
      default: r = ($urandom_range(0, 99) < 65);
    endcase
    m1.tready = r;
    m0.tready = r;
  endtask

  task automatic send(input bit sel, input logic [7:0] b, input bit last);
    int n = 0;
    logic hs;
    if (sel) begin s1.tdata = b; s1.tlast = last; s1.tvalid = 1'b1; end
    else     begin s0.tdata = b; s0.tlast = last; s0.tvalid = 1'b1; end
    do begin
      step();
      n++;
      hs = sel ? hs1 : hs0;
    end while (!hs && n < 200);
    chk("send_accepted", 32'(hs), 32'd1);
    if (sel) s1.tvalid = 1'b0; else s0.tvalid = 1'b0;
  endtask

  // Reference: optional SOF, then each byte (reserved ones as ESC + byte^0x20), tlast on the final beat.
  task automatic send_frame(input bit sel, input int gap_max);
    int nb = frm.size();
    if (sel) begin exp1.push_back({1'b0, 8'hD5}); exp_fr1++; end else exp_fr0++;
    for (int i = 0; i < nb; i++) begin
      logic lst = (i == nb - 1);
      if (frm[i] == 8'hD5 || frm[i] == 8'hE5) begin
        if (sel) begin exp1.push_back({1'b0, 8'hE5}); exp1.push_back({lst, frm[i] ^ 8'h20}); exp_es1++; end
        else     begin exp0.push_back({1'b0, 8'hE5}); exp0.push_back({lst, frm[i] ^ 8'h20}); exp_es0++; end
      end else begin
        if (sel) exp1.push_back({lst, frm[i]}); else exp0.push_back({lst, frm[i]});
      end
    end
    for (int i = 0; i < nb; i++) begin
      repeat ($urandom_range(0, gap_max)) step();
      send(sel, frm[i], i == nb - 1);
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    rdy_mode = 0;
    while ((got1.size() < exp1.size() || got0.size() < exp0.size()) && n < 400) begin
      step();
      n++;
    end
    repeat (4) step();
    chk({tag, "_len1"}, 32'(got1.size()), 32'(exp1.size()));
    chk({tag, "_len0"}, 32'(got0.size()), 32'(exp0.size()));
    for (int i = 0; i < exp1.size() && i < got1.size(); i++)
      chk($sformatf("%s_beat1_%0d", tag, i), 32'(got1[i]), 32'(exp1[i]));
    for (int i = 0; i < exp0.size() && i < got0.size(); i++)
      chk($sformatf("%s_beat0_%0d", tag, i), 32'(got0[i]), 32'(exp0[i]));
    chk({tag, "_frames1"},  32'(fr1), 32'(16'(exp_fr1)));
    chk({tag, "_escapes1"}, 32'(es1), 32'(16'(exp_es1)));
    chk({tag, "_frames0"},  32'(fr0), 32'(16'(exp_fr0)));
    chk({tag, "_escapes0"}, 32'(es0), 32'(16'(exp_es0)));
    got1.delete(); exp1.delete(); got0.delete(); exp0.delete();
  endtask

  initial begin
    int nfr;
    bit sel;
    logic [7:0] b;
    logic seen_f5;
    s1.tvalid = 1'b0; s1.tdata = '0; s1.tlast = 1'b0;
    s0.tvalid = 1'b0; s0.tdata = '0; s0.tlast = 1'b0;
    m1.tready = 1'b1; m0.tready = 1'b1;
    rstn = 1'b0;
    step();
    // Input offered during reset must not be taken.
    s1.tvalid = 1'b1; s1.tdata = 8'h77;
    step();
    chk("rst_tvalid", 32'(m1.tvalid), 32'd0);
    chk("rst_tdata",  32'(m1.tdata),  32'd0);
    chk("rst_tlast",  32'(m1.tlast),  32'd0);
    chk("rst_tready", 32'(s1.tready), 32'd0);
    chk("rst_frames", 32'(fr1), 32'd0);
    chk("rst_escapes", 32'(es1), 32'd0);
    s1.tvalid = 1'b0;
    rstn = 1'b1;
    step();
    chk("sof_idle_no_output", 32'(m1.tvalid), 32'd0);

    frm = {8'h11, 8'h22, 8'h33};
    send_frame(1'b1, 0);
    drain("plain");

    frm = {8'hD5, 8'h11, 8'hE5};
    send_frame(1'b1, 0);
    drain("escaped");

    frm = {8'h44};
    send_frame(1'b1, 0);
    frm = {8'h55};
    send_frame(1'b1, 0);
    drain("b2b");

    rdy_mode = 1;
    frm = {8'hD5, 8'h11, 8'hE5};
    send_frame(1'b1, 0);
    drain("toggle");

    frm = {8'h10, 8'hD5};
    send_frame(1'b0, 0);
    drain("nosof");

    // Reset while the escaped byte is pending in the hold register.
    rdy_mode = 0;
    send(1'b1, 8'hE5, 1'b0);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    chk("esc_rst_frames",  32'(fr1), 32'd0);
    chk("esc_rst_escapes", 32'(es1), 32'd0);
    chk("esc_rst_tvalid",  32'(m1.tvalid), 32'd0);
    repeat (5) step();
    seen_f5 = 1'b0;
    foreach (got1[i]) if (got1[i][7:0] == 8'hF5) seen_f5 = 1'b1;
    chk("esc_rst_no_f5", 32'(seen_f5), 32'd0);
    chk("esc_rst_beats", 32'(got1.size()), 32'd1);
    if (got1.size() > 0) chk("esc_rst_sof", 32'(got1[0]), 32'h0D5);
    got1.delete(); got0.delete();
    exp_fr1 = 0; exp_es1 = 0; exp_fr0 = 0; exp_es0 = 0;
    frm = {8'h66};
    send_frame(1'b1, 0);
    drain("after_rst");

    for (int f = 0; f < 30; f++) begin
      rdy_mode = 2;
      sel = ($urandom_range(0, 3) != 0);
      nfr = $urandom_range(1, 6);
      frm.delete();
      for (int i = 0; i < nfr; i++) begin
        case ($urandom_range(0, 9))
          0:       b = 8'hD5;
          1:       b = 8'hE5;
          default: b = 8'($urandom);
        endcase
        frm.push_back(b);
      end
      send_frame(sel, 2);
    end
    drain("random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
